vs_spi_sched: RTL and testbench
===============================

# vs_spi_sched

SPI bus scheduler for the VS10xx decoder in the mp3 player. It shares one SPI serializer between two requesters: the SCI command path (volume/mode register writes) and the SDI data path (mp3 byte stream). It gates all traffic on `i_DREQ` and drives the decoder chip-selects, `o_SCK` and `o_SI`. It sits between the player control FSM/file reader and the decoder pins.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCK half-period; must be ≥2.
- `BURST_LEN`, 32: maximum SDI bytes per `o_XDCS`-low burst.
- `GAP_CYCLES`, 2: cycles both chip-selects stay high between frames; must be ≥1.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_DREQ` in 1: decoder ready for ≥32 bytes or one command.
- `i_pause` in 1: block new SDI grants.
- `i_cmd_valid` in 1: SCI write request.
- `i_cmd_addr` in 8: SCI register address.
- `i_cmd_data` in 16: SCI register value.
- `o_cmd_ready` out 1: 1-cycle accept pulse for the command.
- `o_cmd_done` out 1: 1-cycle pulse when the SCI frame completes.
- `i_dat_valid` in 1: SDI byte available.
- `i_dat_byte` in 8: SDI byte.
- `o_dat_ready` out 1: 1-cycle accept pulse for the byte.
- `o_XCS` out 1: SCI chip-select, active-low.
- `o_XDCS` out 1: SDI chip-select, active-low.
- `o_SCK` out 1: SPI clock, mode 0, idle low.
- `o_SI` out 1: SPI data, MSB first.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - SCI: shift a 32-bit frame.
  - SDI: shift burst bytes.
  - GAP: both chip-selects held high.
- Arbitration happens in IDLE only, and only when `i_DREQ`=1.
  - Command candidate: `i_cmd_valid`.
  - Data candidate: `i_dat_valid` && !`i_pause`.
  - Both candidates present: the command wins, unless the last grant was a command. In that case data wins (alternation).
  - No candidate, or `i_DREQ`=0: stay in IDLE.
- SCI grant:
  - Pulse `o_cmd_ready` and latch addr/data.
  - Frame is {8'h02, addr, data[15:8], data[7:0]}, with `o_XCS` low for all 32 bits.
  - Go to GAP and pulse `o_cmd_done` on GAP entry.
- SDI grant:
  - Pulse `o_dat_ready` and load the byte. `o_XDCS` falls.
  - At each byte boundary, if bytes sent < `BURST_LEN` and `i_dat_valid` && !`i_pause`, pulse `o_dat_ready` and load the next byte. Otherwise go to GAP.
  - `i_DREQ` is ignored inside a burst, because the decoder guarantees 32 bytes of space.
- Bit engine:
  - `o_SI` is set while `o_SCK` is low.
  - `o_SCK` is low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles. One bit takes 2·`CLK_DIV` cycles.
  - Consecutive bytes in a frame or burst are gapless.
- GAP: hold both chip-selects high, `o_SCK`=0 and `o_SI`=0 for `GAP_CYCLES`, then return to IDLE.
- `o_XCS` and `o_XDCS` are never low simultaneously.
- Reset values: `o_XCS`=1, `o_XDCS`=1, `o_SCK`=0, `o_SI`=0, all ready/done pulses 0, `o_busy`=0, last-grant=data (so the first contention goes to the command).
- `rst` asserted mid-frame: all outputs return to their reset values immediately. The frame is lost and the requester is not notified.
- A pause asserted mid-byte finishes that byte, then the burst ends.

## Timing
- Accept pulse at cycle T.
  - Chip-select low and first `o_SI` bit at T+1.
  - First `o_SCK` rise at T+1+`CLK_DIV`.
- SCI frame: chip-select rises at T+1+64·`CLK_DIV` (last SCK falling edge), with `o_cmd_done` in that same cycle.
- SDI burst of N bytes: `o_XDCS` rises at T+1+16·N·`CLK_DIV`.
- Subsequent `o_dat_ready` pulses occur one cycle before each byte's first bit, i.e. at T+16·k·`CLK_DIV`.
- Earliest next grant: `GAP_CYCLES` cycles after chip-select rises.
- Outputs are registered; no combinational path from inputs to pins.

## Structure
- Package `vs_pkg` holds:
  - `SCI_WRITE_OP`=8'h02.
  - `SCI_MODE`=8'h00.
  - `SCI_VOL`=8'h0B.
  - The state enum.
- Sub-module `vs_spi_shifter` handles load/byte-done handshake, SCK divider, 8-bit shift, and bit counter. The scheduler FSM, burst counter and arbitration live in the top.

## Test plan
- Command: `i_DREQ`=1, `CLK_DIV`=4, command addr 0x0B data 0x2020. Required: `o_XCS` low 256 cycles; SI bits 0x020B2020; one `o_cmd_done`; `o_XDCS` stays 1.
- Data stream: `i_dat_valid` held high with 40 bytes. Required: first burst of exactly 32 `o_dat_ready` pulses, `o_XDCS` rises, ≥2 cycles high, second burst of 8.
- Contention: `i_DREQ`=0 while command and data are both pending, then `i_DREQ`=1. Required: command first, then data burst, with no XCS/XDCS overlap.
- Pause: `i_pause` raised during byte 5 of a burst. Required: byte 5 completes, `o_XDCS` rises, no grants while paused, resume after release.
- Reset mid-frame: assert `rst` during SCI bit 12. Required: `o_XCS`=1, `o_SCK`=0, `o_busy`=0 immediately; the next command runs a full, correct frame.

Source files
------------

// File: rtl/vs_spi_sched_pkg.sv
// vs_pkg: shared constants, state encoding and frame builder for the
// VS10xx SPI scheduler.
package vs_pkg;

    localparam logic [7:0] SCI_WRITE_OP = 8'h02;
    localparam logic [7:0] SCI_MODE     = 8'h00;
    localparam logic [7:0] SCI_VOL      = 8'h0B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCI  = 2'd1,
        ST_SDI  = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_e;

    // Full 32-bit SCI write frame, shifted MSB first.
    function automatic logic [31:0] sci_frame(input logic [7:0] addr, input logic [15:0] data);
        return {SCI_WRITE_OP, addr, data[15:8], data[7:0]};
    endfunction

endpackage

// File: rtl/vs_spi_sched_if.sv
// Requester-side bundle of the scheduler: SCI command and SDI byte handshakes.
interface vs_spi_sched_if;

    logic        i_pause;
    logic        i_cmd_valid;
    logic [7:0]  i_cmd_addr;
    logic [15:0] i_cmd_data;
    logic        o_cmd_ready;
    logic        o_cmd_done;
    logic        i_dat_valid;
    logic [7:0]  i_dat_byte;
    logic        o_dat_ready;

    // Requester side (player FSM / file reader).
    modport master (
        output i_pause, i_cmd_valid, i_cmd_addr, i_cmd_data, i_dat_valid, i_dat_byte,
        input  o_cmd_ready, o_cmd_done, o_dat_ready
    );

    // Scheduler side.
    modport slave (
        input  i_pause, i_cmd_valid, i_cmd_addr, i_cmd_data, i_dat_valid, i_dat_byte,
        output o_cmd_ready, o_cmd_done, o_dat_ready
    );

endinterface

// File: rtl/vs_spi_sched_shifter.sv
// vs_spi_shifter: SPI mode-0 byte serializer. A load starts a byte; the
// near-done flag fires one cycle before the final SCK fall so the owner can
// register a reload that lands exactly on that fall (gapless bytes).
module vs_spi_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       sck_o,
    output logic       si_o,
    output logic       near_done_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          active_q;
    logic          sck_q;
    logic          si_q;
    logic          phase_end;

    assign phase_end = (div_q == CW'(CLK_DIV - 1));

    // Half-period divider, SCK toggle and MSB-first shift; a load overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            si_q     <= 1'b0;
        end else if (load_i) begin
            shreg_q  <= {byte_i[6:0], 1'b0};
            si_q     <= byte_i[7];
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (phase_end) begin
                div_q <= '0;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                end else begin
                    sck_q <= 1'b0;
                    if (bit_q == 3'd7) begin
                        active_q <= 1'b0;
                        si_q     <= 1'b0;
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        si_q    <= shreg_q[7];
                        shreg_q <= {shreg_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_q <= div_q + CW'(1);
            end
        end
    end

    assign sck_o       = sck_q;
    assign si_o        = si_q;
    assign near_done_o = active_q && sck_q && (bit_q == 3'd7) && (div_q == CW'(CLK_DIV - 2));

endmodule

// File: rtl/vs_spi_sched.sv
// vs_spi_sched: arbitrates the SCI command path and SDI data path onto one
// SPI serializer, gated by DREQ, and drives the VS10xx chip-selects.
module vs_spi_sched
    import vs_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int BURST_LEN  = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_DREQ,
    vs_spi_sched_if.slave     req,
    output logic              o_XCS,
    output logic              o_XDCS,
    output logic              o_SCK,
    output logic              o_SI,
    output logic              o_busy
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sched_state_e  state_q;
    logic          last_cmd_q;
    logic          cmd_ready_q;
    logic          cmd_done_q;
    logic          dat_ready_q;
    logic          load_q;
    logic          near_q;
    logic [7:0]    byte_q;
    logic [23:0]   frame_q;
    logic [1:0]    left_q;
    logic [BW-1:0] burst_q;
    logic [GW-1:0] gap_q;
    logic          xcs_q;
    logic          xdcs_q;

    logic          near_done;
    logic          cmd_cand;
    logic          dat_cand;
    logic [31:0]   frame_w;

    assign cmd_cand = req.i_cmd_valid;
    assign dat_cand = req.i_dat_valid && !req.i_pause;
    assign frame_w  = sci_frame(req.i_cmd_addr, req.i_cmd_data);

    vs_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_q),
        .byte_i     (byte_q),
        .sck_o      (o_SCK),
        .si_o       (o_SI),
        .near_done_o(near_done)
    );

    // Scheduler FSM: arbitration, frame/burst sequencing, chip-selects and pulses.
    // A requested item is captured at the same edge that raises its accept pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_cmd_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            dat_ready_q <= 1'b0;
            load_q      <= 1'b0;
            near_q      <= 1'b0;
            byte_q      <= '0;
            frame_q     <= '0;
            left_q      <= '0;
            burst_q     <= '0;
            gap_q       <= '0;
            xcs_q       <= 1'b1;
            xdcs_q      <= 1'b1;
        end else begin
            cmd_ready_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            dat_ready_q <= 1'b0;
            load_q      <= 1'b0;
            near_q      <= near_done;
            case (state_q)
                ST_IDLE: begin
                    if (i_DREQ) begin
                        if (cmd_cand && (!dat_cand || !last_cmd_q)) begin
                            state_q     <= ST_SCI;
                            cmd_ready_q <= 1'b1;
                            load_q      <= 1'b1;
                            last_cmd_q  <= 1'b1;
                            byte_q      <= frame_w[31:24];
                            frame_q     <= frame_w[23:0];
                            left_q      <= 2'd3;
                        end else if (dat_cand) begin
                            state_q     <= ST_SDI;
                            dat_ready_q <= 1'b1;
                            load_q      <= 1'b1;
                            last_cmd_q  <= 1'b0;
                            byte_q      <= req.i_dat_byte;
                            burst_q     <= BW'(1);
                        end
                    end
                end
                ST_SCI: begin
                    if (load_q) begin
                        xcs_q <= 1'b0;
                    end
                    if (near_done) begin
                        if (left_q != 2'd0) begin
                            load_q  <= 1'b1;
                            byte_q  <= frame_q[23:16];
                            frame_q <= {frame_q[15:0], 8'h00};
                            left_q  <= left_q - 2'd1;
                        end
                    end else if (near_q && !load_q) begin
                        state_q    <= ST_GAP;
                        xcs_q      <= 1'b1;
                        cmd_done_q <= 1'b1;
                        gap_q      <= '0;
                    end
                end
                ST_SDI: begin
                    if (load_q) begin
                        xdcs_q <= 1'b0;
                    end
                    if (near_done) begin
                        // DREQ is not consulted here: a burst fits the decoder FIFO.
                        if ((burst_q < BW'(BURST_LEN)) && dat_cand) begin
                            load_q      <= 1'b1;
                            dat_ready_q <= 1'b1;
                            byte_q      <= req.i_dat_byte;
                            burst_q     <= burst_q + BW'(1);
                        end
                    end else if (near_q && !load_q) begin
                        state_q <= ST_GAP;
                        xdcs_q  <= 1'b1;
                        gap_q   <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req.o_cmd_ready = cmd_ready_q;
    assign req.o_cmd_done  = cmd_done_q;
    assign req.o_dat_ready = dat_ready_q;
    assign o_XCS           = xcs_q;
    assign o_XDCS          = xdcs_q;
    assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vs_spi_sched.sv
// Directed bench for vs_spi_sched: command frame, burst splitting, contention
// and alternation, pause, and reset in the middle of an SCI frame.
module tb_vs_spi_sched;
    import vs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dreq = 1'b0;
    logic o_XCS, o_XDCS, o_SCK, o_SI, o_busy;

    vs_spi_sched_if req_if ();

    vs_spi_sched #(.CLK_DIV(4), .BURST_LEN(32), .GAP_CYCLES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_DREQ(dreq),
        .req   (req_if),
        .o_XCS (o_XCS),
        .o_XDCS(o_XDCS),
        .o_SCK (o_SCK),
        .o_SI  (o_SI),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // requester bookkeeping
    int cmd_req = 0;
    int cmd_issued = 0;
    int dat_total = 0;
    int dat_idx = 0;
    logic cmd_acc, dat_acc;
    logic [7:0]  cmd_addr_tab [8] = '{SCI_VOL, SCI_VOL, SCI_MODE, SCI_VOL, SCI_MODE, 8'h00, 8'h00, 8'h00};
    logic [15:0] cmd_data_tab [8] = '{16'h2020, 16'h1010, 16'h0800, 16'hFFFF, 16'h0804, 16'h0, 16'h0, 16'h0};

    // monitor state
    int cyc = 0;
    int dat_ready_cnt = 0, cmd_ready_cnt = 0, cmd_ready_cyc = 0;
    int done_cnt = 0, done_at_rise = 0, overlap_cnt = 0;
    int si_bits = 0, xcs_rises = 0, xdcs_rises = 0;
    int xcs_fall_cyc = 0, xcs_len = 0, xcs_lat = 0, sck_lat = 0;
    int xdcs_fall_cyc = 0, burst_base = 0, gap_cur = 0, xdcs_gap_last = 0;
    logic xcs_first_pend = 1'b0;
    logic prev_sck = 1'b0, prev_xcs = 1'b1, prev_xdcs = 1'b1;
    logic [63:0] si_hist = '0;
    logic [7:0] sdi_sh = '0;
    int sdi_nb = 0;
    logic [7:0]  sdi_bytes_q[$];
    logic [31:0] frame_q[$];
    int burst_q[$];
    int xdcs_len_q[$];
    int order_q[$];

    function automatic logic [7:0] byte_of(input int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // which: 0 XCS rises, 1 XDCS rises, 2 data accepts, 3 SI bits
    task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
        int v;
        v = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0: v = xcs_rises;
                1: v = xdcs_rises;
                2: v = dat_ready_cnt;
                default: v = si_bits;
            endcase
            if (v >= target) break;
        end
        if (v < target) chk({tag, "_timeout"}, 32'(v), 32'(target));
    endtask

    // Bus monitor: edges, frame/burst lengths and captured serial data.
    always @(negedge clk) begin
        cyc++;
        if (req_if.o_dat_ready) dat_ready_cnt++;
        if (req_if.o_cmd_ready) begin
            cmd_ready_cnt++;
            cmd_ready_cyc = cyc;
        end
        if (req_if.o_cmd_done) begin
            done_cnt++;
            if (!prev_xcs && o_XCS) done_at_rise++;
        end
        if (!o_XCS && !o_XDCS) overlap_cnt++;
        if (o_SCK && !prev_sck) begin
            si_hist = {si_hist[62:0], o_SI};
            si_bits++;
            if (xcs_first_pend) begin
                sck_lat = cyc - xcs_fall_cyc;
                xcs_first_pend = 1'b0;
            end
            if (!o_XDCS) begin
                sdi_sh = {sdi_sh[6:0], o_SI};
                sdi_nb++;
                if (sdi_nb == 8) begin
                    sdi_bytes_q.push_back(sdi_sh);
                    sdi_nb = 0;
                end
            end
        end
        if (prev_xcs && !o_XCS) begin
            xcs_fall_cyc = cyc;
            xcs_lat = cyc - cmd_ready_cyc;
            xcs_first_pend = 1'b1;
            order_q.push_back(1);
        end
        if (!prev_xcs && o_XCS) begin
            xcs_len = cyc - xcs_fall_cyc;
            xcs_rises++;
            frame_q.push_back(si_hist[31:0]);
            $display("sci frame: %0d cycles, bits 0x%08h", xcs_len, si_hist[31:0]);
        end
        if (prev_xdcs && !o_XDCS) begin
            xdcs_fall_cyc = cyc;
            burst_base = dat_ready_cnt - 1;
            xdcs_gap_last = gap_cur;
            sdi_nb = 0;
            order_q.push_back(2);
        end
        if (!prev_xdcs && o_XDCS) begin
            xdcs_len_q.push_back(cyc - xdcs_fall_cyc);
            burst_q.push_back(dat_ready_cnt - burst_base);
            xdcs_rises++;
            gap_cur = 0;
            $display("sdi burst: %0d bytes, %0d cycles", dat_ready_cnt - burst_base, cyc - xdcs_fall_cyc);
        end
        if (o_XDCS) gap_cur++;
        prev_sck = o_SCK;
        prev_xcs = o_XCS;
        prev_xdcs = o_XDCS;
    end

    // Command requester: presents table entries, advances after each accept pulse.
    initial begin
        req_if.i_cmd_valid = 1'b0;
        req_if.i_cmd_addr = '0;
        req_if.i_cmd_data = '0;
        forever begin
            @(negedge clk);
            cmd_acc = req_if.o_cmd_ready;
            @(posedge clk);
            #1;
            if (cmd_acc) cmd_issued++;
            req_if.i_cmd_valid = (cmd_issued < cmd_req);
            req_if.i_cmd_addr = cmd_addr_tab[cmd_issued % 8];
            req_if.i_cmd_data = cmd_data_tab[cmd_issued % 8];
        end
    end

    // Data requester: byte stream byte_of(idx), advances after each accept pulse.
    initial begin
        req_if.i_dat_valid = 1'b0;
        req_if.i_dat_byte = '0;
        forever begin
            @(negedge clk);
            dat_acc = req_if.o_dat_ready;
            @(posedge clk);
            #1;
            if (dat_acc) dat_idx++;
            req_if.i_dat_valid = (dat_idx < dat_total);
            req_if.i_dat_byte = byte_of(dat_idx);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, r0, c0, d0, o0, f0, xr;
        req_if.i_pause = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_xcs", 32'(o_XCS), 32'd1);
        chk("rst_xdcs", 32'(o_XDCS), 32'd1);
        chk("rst_sck", 32'(o_SCK), 32'd0);
        chk("rst_si", 32'(o_SI), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cmd_ready", 32'(req_if.o_cmd_ready), 32'd0);
        chk("rst_dat_ready", 32'(req_if.o_dat_ready), 32'd0);
        chk("rst_cmd_done", 32'(req_if.o_cmd_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1) single SCI write: VOL = 0x2020
        dreq = 1'b1;
        cmd_req = 1;
        wait_cnt("cmd1", 0, 1, 2000);
        repeat (3) @(negedge clk);
        chk("cmd1_xcs_len", 32'(xcs_len), 32'd256);
        chk("cmd1_frame", frame_q[0], 32'h020B2020);
        chk("cmd1_done_cnt", 32'(done_cnt), 32'd1);
        chk("cmd1_done_at_rise", 32'(done_at_rise), 32'd1);
        chk("cmd1_xdcs_idle", 32'(xdcs_rises), 32'd0);
        chk("cmd1_cs_latency", 32'(xcs_lat), 32'd1);
        chk("cmd1_sck_latency", 32'(sck_lat), 32'd4);

        // 2) 40-byte stream splits into 32 + 8; DREQ dropped mid-burst is ignored
        b = burst_q.size();
        dat_total = 40;
        wait_cnt("dat_first", 2, 1, 100);
        dreq = 1'b0;
        repeat (200) @(negedge clk);
        dreq = 1'b1;
        wait_cnt("dat_bursts", 1, 2, 6000);
        repeat (3) @(negedge clk);
        chk("dat_burst1_len", 32'(burst_q[b]), 32'd32);
        chk("dat_burst2_len", 32'(burst_q[b + 1]), 32'd8);
        chk("dat_burst1_cycles", 32'(xdcs_len_q[b]), 32'd2048);
        chk("dat_burst2_cycles", 32'(xdcs_len_q[b + 1]), 32'd512);
        chk("dat_gap_ge2", 32'(xdcs_gap_last >= 2), 32'd1);
        chk("dat_nbytes", 32'(sdi_bytes_q.size()), 32'd40);
        chk("dat_byte0", 32'(sdi_bytes_q[0]), 32'(byte_of(0)));
        chk("dat_byte31", 32'(sdi_bytes_q[31]), 32'(byte_of(31)));
        chk("dat_byte32", 32'(sdi_bytes_q[32]), 32'(byte_of(32)));
        chk("dat_byte39", 32'(sdi_bytes_q[39]), 32'(byte_of(39)));

        // 3) contention held off by DREQ=0, then cmd / data / cmd alternation
        dreq = 1'b0;
        o0 = order_q.size();
        f0 = frame_q.size();
        b = burst_q.size();
        cmd_req = 3;
        dat_total = 44;
        repeat (3) @(negedge clk);
        r0 = dat_ready_cnt;
        c0 = cmd_ready_cnt;
        repeat (20) @(negedge clk);
        chk("cont_hold_busy", 32'(o_busy), 32'd0);
        chk("cont_hold_cmd", 32'(cmd_ready_cnt), 32'(c0));
        chk("cont_hold_dat", 32'(dat_ready_cnt), 32'(r0));
        dreq = 1'b1;
        wait_cnt("cont_cmds", 0, xcs_rises + 2, 3000);
        repeat (3) @(negedge clk);
        chk("cont_order0", 32'(order_q[o0]), 32'd1);
        chk("cont_order1", 32'(order_q[o0 + 1]), 32'd2);
        chk("cont_order2", 32'(order_q[o0 + 2]), 32'd1);
        chk("cont_frame0", frame_q[f0], 32'h020B1010);
        chk("cont_frame1", frame_q[f0 + 1], 32'h02000800);
        chk("cont_burst_len", 32'(burst_q[b]), 32'd4);
        chk("cont_overlap", 32'(overlap_cnt), 32'd0);

        // 4) pause raised during byte 5 ends the burst after that byte
        b = burst_q.size();
        r0 = dat_ready_cnt;
        dat_total = 54;
        wait_cnt("pause_b5", 2, r0 + 5, 800);
        repeat (10) @(negedge clk);
        req_if.i_pause = 1'b1;
        wait_cnt("pause_end", 1, xdcs_rises + 1, 200);
        repeat (2) @(negedge clk);
        chk("pause_burst_len", 32'(burst_q[b]), 32'd5);
        r0 = dat_ready_cnt;
        repeat (100) @(negedge clk);
        chk("pause_no_grant", 32'(dat_ready_cnt), 32'(r0));
        chk("pause_xdcs_high", 32'(o_XDCS), 32'd1);
        req_if.i_pause = 1'b0;
        wait_cnt("pause_resume", 1, xdcs_rises + 1, 800);
        repeat (3) @(negedge clk);
        chk("resume_burst_len", 32'(burst_q[b + 1]), 32'd5);
        chk("resume_last_byte", 32'(sdi_bytes_q[53]), 32'(byte_of(53)));

        // 5) reset during SCI bit 12, then a clean frame
        d0 = done_cnt;
        r0 = si_bits;
        cmd_req = 4;
        wait_cnt("rst_bit12", 3, r0 + 12, 800);
        chk("rst_busy_mid", 32'(o_busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_xcs", 32'(o_XCS), 32'd1);
        chk("rst_mid_sck", 32'(o_SCK), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_si", 32'(o_SI), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt), 32'(d0));
        xr = xcs_rises;
        cmd_req = 5;
        wait_cnt("rst_next_cmd", 0, xr + 1, 800);
        repeat (3) @(negedge clk);
        chk("rst_next_frame", frame_q[frame_q.size() - 1], 32'h02000804);
        chk("rst_next_len", 32'(xcs_len), 32'd256);
        chk("rst_next_done", 32'(done_cnt), 32'(d0 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
